// File: rtl/common.sv
// Shared cbus types and constants used by initiators, interconnect and the
// RAM-backed responder.
package common;

    localparam int unsigned CBUS_DATA_W        = 64;
    localparam int unsigned CBUS_STRB_W        = CBUS_DATA_W / 8;
    localparam int unsigned CBUS_RAM_LATENCY_W = 8;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // log2 of the access size in bytes; len is beats minus one
    typedef logic [2:0] msize_t;
    typedef logic [7:0] mlen_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        msize_t                 size;
        logic [63:0]            addr;
        logic [CBUS_STRB_W-1:0] strobe;
        logic [CBUS_DATA_W-1:0] data;
        mlen_t                  len;
        logic [1:0]             burst;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2,
        TURN = 2'd3
    } ram_state_t;

endpackage

// File: rtl/strobe_ram.sv
// Single-port word RAM with per-byte write enables and asynchronous read,
// shaped to map onto distributed RAM.
module strobe_ram
    import common::*;
#(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [CBUS_STRB_W-1:0] be,
    input  logic [AW-1:0]          addr,
    input  logic [CBUS_DATA_W-1:0] wdata,
    output logic [CBUS_DATA_W-1:0] rdata
);

    logic [CBUS_DATA_W-1:0] mem_q [WORDS];

    // NOTE: the array has no reset branch; a reset would force it into
    // flip-flops and stop it from mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < CBUS_STRB_W; b++) begin
                if (be[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/cbus_ram_responder.sv
// cbus responder backed by strobe_ram: programmable first-beat latency,
// FIXED/INCR bursts, byte-strobed writes, fully registered response.
module cbus_ram_responder
    import common::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireq,
    output cbus_resp_t iresp
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [CBUS_RAM_LATENCY_W-1:0] LAT_LOAD = CBUS_RAM_LATENCY_W'(LATENCY);

    ram_state_t                    state_q, state_d;
    logic                          is_write_q, is_write_d;
    logic [1:0]                    burst_q, burst_d;
    logic                          in_range_q, in_range_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [CBUS_RAM_LATENCY_W-1:0] lat_cnt_q, lat_cnt_d;
    mlen_t                         beat_cnt_q, beat_cnt_d;
    logic                          ready_q, ready_d;
    logic                          last_q, last_d;
    logic [CBUS_DATA_W-1:0]        data_q, data_d;

    logic [63:0]            req_offset;
    logic [63:0]            req_word;
    logic                   req_in_range;
    logic [IDX_W-1:0]       req_idx;
    logic                   handshake;
    logic [IDX_W-1:0]       idx_adv;
    logic                   ram_we;
    logic [IDX_W-1:0]       ram_addr;
    logic [CBUS_DATA_W-1:0] ram_rdata;
    logic [CBUS_DATA_W-1:0] rd_word;
    logic                   unused_size;

    // Range is judged on the untruncated word offset; addresses below the
    // base wrap to a huge offset and fail the same comparison.
    assign req_offset   = ireq.addr - BASE_ADDR;
    assign req_word     = req_offset >> 3;
    assign req_in_range = (ireq.addr >= BASE_ADDR) && (req_word < 64'(MEM_WORDS));
    assign req_idx      = req_word[IDX_W-1:0];
    assign unused_size  = ^ireq.size;

    // A beat completes on an edge where the registered ready is up and the
    // initiator is still holding valid.
    assign handshake = (state_q == BEAT) && ready_q && ireq.valid;
    assign idx_adv   = (burst_q == AXI_BURST_FIXED) ? idx_q : idx_q + IDX_W'(1);
    assign ram_we    = handshake && is_write_q && in_range_q;
    assign ram_addr  = (handshake && !is_write_q) ? idx_adv : idx_q;
    assign rd_word   = (!is_write_q && in_range_q) ? ram_rdata : '0;

    strobe_ram #(
        .WORDS (MEM_WORDS),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ireq.strobe),
        .addr  (ram_addr),
        .wdata (ireq.data),
        .rdata (ram_rdata)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        burst_d    = burst_q;
        in_range_d = in_range_q;
        idx_d      = idx_q;
        lat_cnt_d  = lat_cnt_q;
        beat_cnt_d = beat_cnt_q;
        ready_d    = 1'b0;
        last_d     = 1'b0;
        data_d     = '0;

        unique case (state_q)
            IDLE: begin
                if (ireq.valid) begin
                    is_write_d = ireq.is_write;
                    burst_d    = ireq.burst;
                    in_range_d = req_in_range;
                    idx_d      = req_idx;
                    lat_cnt_d  = LAT_LOAD;
                    beat_cnt_d = ireq.len;
                    state_d    = (LATENCY == 0) ? BEAT : WAIT;
                end
            end
            WAIT: begin
                if (!ireq.valid) begin
                    state_d = TURN;
                end else begin
                    lat_cnt_d = lat_cnt_q - CBUS_RAM_LATENCY_W'(1);
                    if (lat_cnt_d == '0) begin
                        state_d = BEAT;
                    end
                end
            end
            BEAT: begin
                if (!ireq.valid) begin
                    state_d = TURN;
                end else if (!ready_q) begin
                    // first beat is being presented, nothing handshaken yet
                    ready_d = 1'b1;
                    last_d  = (beat_cnt_q == '0);
                    data_d  = rd_word;
                end else begin
                    idx_d = idx_adv;
                    if (last_q) begin
                        state_d = TURN;
                    end else begin
                        beat_cnt_d = beat_cnt_q - mlen_t'(1);
                        ready_d    = 1'b1;
                        last_d     = (beat_cnt_d == '0);
                        data_d     = rd_word;
                    end
                end
            end
            TURN: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            burst_q    <= AXI_BURST_FIXED;
            in_range_q <= 1'b0;
            idx_q      <= '0;
            lat_cnt_q  <= '0;
            beat_cnt_q <= '0;
            ready_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            burst_q    <= burst_d;
            in_range_q <= in_range_d;
            idx_q      <= idx_d;
            lat_cnt_q  <= lat_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            ready_q    <= ready_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    assign iresp = '{ready: ready_q, last: last_q, data: data_q};

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed and random transfers against a word-array model of the RAM,
// checking beat timing, last, read data and write effects.
module tb_cbus_ram_responder;
    import common::*;

    localparam int unsigned MEM_WORDS = 16;
    localparam int unsigned LAT       = 2;
    localparam logic [63:0] BASE      = 64'h8000_0000;

    logic       clk;
    logic       reset;
    cbus_req_t  ireq;
    cbus_resp_t iresp;

    int tests_run = 0;
    int fail_cnt  = 0;

    logic [63:0] model    [MEM_WORDS];
    logic [63:0] wr_data  [16];
    logic [7:0]  wr_strb  [16];
    logic [63:0] rd_beats [16];
    logic [63:0] last_rd;

    cbus_ram_responder #(
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LAT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exhausted");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer from the initiator side. abort_at / reset_at name the beat
    // at which valid is dropped or reset is pulsed (-1 = never).
    task automatic xfer(input logic wr, input logic [63:0] addr, input int len,
                        input logic [1:0] burst, input int abort_at, input int reset_at);
        logic [63:0] off;
        logic        in_rng;
        int          base_idx;
        int          idx;
        int          j;
        logic [63:0] exp;

        off      = addr - BASE;
        in_rng   = (addr >= BASE) && ((off >> 3) < 64'(MEM_WORDS));
        base_idx = int'((off >> 3) % 64'(MEM_WORDS));

        @(negedge clk);
        check("idle_ready", 64'(iresp.ready), 64'd0);
        ireq.valid    = 1'b1;
        ireq.is_write = wr;
        ireq.size     = 3'd3;
        ireq.addr     = addr;
        ireq.len      = mlen_t'(len);
        ireq.burst    = burst;
        ireq.data     = wr_data[0];
        ireq.strobe   = wr_strb[0];

        for (int k = 1; k <= int'(LAT) + 2 + len; k++) begin
            @(negedge clk);
            if (k < int'(LAT) + 2) begin
                check("wait_ready", 64'(iresp.ready), 64'd0);
            end else begin
                j   = k - (int'(LAT) + 2);
                idx = (burst == AXI_BURST_FIXED) ? base_idx : (base_idx + j) % int'(MEM_WORDS);
                check("beat_ready", 64'(iresp.ready), 64'd1);
                check("beat_last", 64'(iresp.last), 64'(j == len));
                if (!wr) begin
                    exp = in_rng ? model[idx] : 64'd0;
                    check("rd_data", iresp.data, exp);
                    rd_beats[j] = iresp.data;
                    last_rd     = iresp.data;
                end
                if (j == abort_at) begin
                    ireq.valid = 1'b0;
                    @(negedge clk);
                    check("abort_ready", 64'(iresp.ready), 64'd0);
                    check("abort_last", 64'(iresp.last), 64'd0);
                    return;
                end
                if (j == reset_at) begin
                    #2 reset = 1'b0;
                    #1;
                    check("rst_ready", 64'(iresp.ready), 64'd0);
                    check("rst_last", 64'(iresp.last), 64'd0);
                    check("rst_data", iresp.data, 64'd0);
                    ireq.valid = 1'b0;
                    @(negedge clk);
                    reset = 1'b1;
                    return;
                end
                if (wr) begin
                    ireq.data   = wr_data[j];
                    ireq.strobe = wr_strb[j];
                    if (in_rng) begin
                        for (int b = 0; b < 8; b++) begin
                            if (wr_strb[j][b]) model[idx][8*b +: 8] = wr_data[j][8*b +: 8];
                        end
                    end
                end
            end
        end

        @(negedge clk);
        check("turn_ready", 64'(iresp.ready), 64'd0);
        check("turn_last", 64'(iresp.last), 64'd0);
        ireq.valid = 1'b0;
    endtask

    initial begin
        logic [63:0] old_word;
        logic [63:0] addr;
        logic [1:0]  burst;
        logic        wr;
        int          len;
        int          sel;
        int          abort_at;

        ireq    = '0;
        reset   = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 16; i++) begin
            wr_data[i]  = '0;
            wr_strb[i]  = 8'hFF;
            rd_beats[i] = '0;
        end
        for (int i = 0; i < int'(MEM_WORDS); i++) model[i] = '0;

        repeat (3) @(negedge clk);
        check("reset_ready", 64'(iresp.ready), 64'd0);
        check("reset_last", 64'(iresp.last), 64'd0);
        check("reset_data", iresp.data, 64'd0);
        reset = 1'b1;

        // fill the whole RAM so the model is fully known
        for (int i = 0; i < 16; i++) begin
            wr_data[i] = {$urandom, $urandom};
            wr_strb[i] = 8'hFF;
        end
        xfer(1'b1, BASE, int'(MEM_WORDS) - 1, AXI_BURST_INCR, -1, -1);

        // single read at latency 2
        wr_data[0] = 64'hDEAD_BEEF_0123_4567;
        wr_strb[0] = 8'hFF;
        xfer(1'b1, BASE, 0, AXI_BURST_INCR, -1, -1);
        xfer(1'b0, BASE, 0, AXI_BURST_INCR, -1, -1);
        check("single_read_data", last_rd, 64'hDEAD_BEEF_0123_4567);

        // strobed write over a zero word
        wr_data[0] = 64'd0;
        wr_strb[0] = 8'hFF;
        xfer(1'b1, BASE + 64'd8, 0, AXI_BURST_INCR, -1, -1);
        wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr_strb[0] = 8'h0F;
        xfer(1'b1, BASE + 64'd8, 0, AXI_BURST_INCR, -1, -1);
        xfer(1'b0, BASE + 64'd8, 0, AXI_BURST_INCR, -1, -1);
        check("strobe_merge", last_rd, 64'h0000_0000_FFFF_FFFF);

        // INCR read wrapping past the top word
        xfer(1'b0, BASE + 64'((MEM_WORDS - 1) * 8), 3, AXI_BURST_INCR, -1, -1);
        check("wrap_beat1", rd_beats[1], 64'hDEAD_BEEF_0123_4567);
        check("wrap_beat2", rd_beats[2], 64'h0000_0000_FFFF_FFFF);

        // FIXED write burst: both beats land on word 5
        old_word   = model[6];
        wr_data[0] = 64'hAAAA_0000_AAAA_0000;
        wr_data[1] = 64'hBBBB_1111_BBBB_1111;
        wr_strb[0] = 8'hFF;
        wr_strb[1] = 8'hFF;
        xfer(1'b1, BASE + 64'd40, 1, AXI_BURST_FIXED, -1, -1);
        xfer(1'b0, BASE + 64'd40, 1, AXI_BURST_INCR, -1, -1);
        check("fixed_mem5", rd_beats[0], 64'hBBBB_1111_BBBB_1111);
        check("fixed_mem6", rd_beats[1], old_word);

        // just below the window
        xfer(1'b0, 64'h7FFF_FFF8, 0, AXI_BURST_INCR, -1, -1);
        check("oor_low_data", last_rd, 64'd0);
        xfer(1'b0, BASE + 64'(MEM_WORDS * 8), 1, AXI_BURST_INCR, -1, -1);

        // abort a len-3 write after its first beat
        old_word = model[9];
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = {$urandom, $urandom};
            wr_strb[i] = 8'hFF;
        end
        xfer(1'b1, BASE + 64'd64, 3, AXI_BURST_INCR, 1, -1);
        xfer(1'b0, BASE + 64'd64, 3, AXI_BURST_INCR, -1, -1);
        check("abort_beat0", rd_beats[0], wr_data[0]);
        check("abort_beat1", rd_beats[1], old_word);

        // reset in the middle of a write burst
        for (int i = 0; i < 6; i++) begin
            wr_data[i] = {$urandom, $urandom};
            wr_strb[i] = 8'hFF;
        end
        xfer(1'b1, BASE + 64'd80, 5, AXI_BURST_INCR, -1, 2);
        xfer(1'b0, BASE + 64'd80, 5, AXI_BURST_INCR, -1, -1);
        check("rst_kept_beat1", rd_beats[1], wr_data[1]);

        // random traffic
        for (int t = 0; t < 40; t++) begin
            wr    = 1'($urandom_range(0, 1));
            len   = int'($urandom_range(0, 5));
            burst = ($urandom_range(0, 1) == 0) ? AXI_BURST_FIXED : AXI_BURST_INCR;
            sel   = int'($urandom_range(0, 9));
            if (sel == 0)
                addr = BASE - 64'(8 * $urandom_range(1, 4));
            else if (sel == 1)
                addr = BASE + 64'(MEM_WORDS * 8) + 64'($urandom_range(0, 63));
            else
                addr = BASE + 64'($urandom_range(0, MEM_WORDS * 8 - 1));
            for (int i = 0; i < 16; i++) begin
                wr_data[i] = {$urandom, $urandom};
                wr_strb[i] = 8'($urandom);
            end
            abort_at = (len > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, len)) : -1;
            xfer(wr, addr, len, burst, abort_at, -1);
        end

        xfer(1'b0, BASE, int'(MEM_WORDS) - 1, AXI_BURST_INCR, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
